// File: rtl/cg_mapper_pkg.sv
// Shared constants for the PRG window mapper: config page decode, register indices, flag layout.
package cg_mapper_pkg;

  localparam logic [2:0] CFG_PAGE = 3'b101;

  localparam logic [2:0] REG_BASE_LO = 3'd0;
  localparam logic [2:0] REG_BASE_HI = 3'd1;
  localparam logic [2:0] REG_MASK_LO = 3'd2;
  localparam logic [2:0] REG_MASK_HI = 3'd3;
  localparam logic [2:0] REG_FLAGS   = 3'd4;

  localparam int FLAG_SRAM_EN  = 0;
  localparam int FLAG_PRG_WE   = 1;
  localparam int FLAG_FIXED    = 2;
  localparam int FLAG_LOCK     = 7;

  typedef struct packed {
    logic lock;
    logic fixed_last;
    logic prg_write_en;
    logic sram_enable;
  } cfg_flags_t;

  function automatic int cg_clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cg_prg_window_mapper_if.sv
// CPU-side bus into the PRG mapper and the translated page / config outputs.
interface cg_prg_window_mapper_if #(
  parameter int BASE_W = 14
);
  logic              romsel;
  logic              cpu_rw;
  logic [14:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              wr_stb;
  logic [BASE_W-1:0] flash_page;
  logic              sram_enable;
  logic              prg_write_en;
  logic              init_done;
  logic              cfg_locked;
  logic [7:0]        cpu_rdata;
  logic              cpu_rdata_oe;

  modport master (
    output romsel, cpu_rw, cpu_addr, cpu_wdata, wr_stb,
    input  flash_page, sram_enable, prg_write_en, init_done, cfg_locked,
           cpu_rdata, cpu_rdata_oe
  );

  modport slave (
    input  romsel, cpu_rw, cpu_addr, cpu_wdata, wr_stb,
    output flash_page, sram_enable, prg_write_en, init_done, cfg_locked,
           cpu_rdata, cpu_rdata_oe
  );
endinterface

// File: rtl/cg_init_timer.sv
// Power-up holdoff: counts m2 edges after reset release and raises init_done after INIT_CYCLES.
module cg_init_timer #(
  parameter int INIT_CYCLES = 15
) (
  input  logic m2,
  input  logic rst_n,
  output logic init_done
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q < CNT_W'(INIT_CYCLES)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge m2) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign init_done = (cnt_q == CNT_W'(INIT_CYCLES));

endmodule

// File: rtl/cg_prg_window_mapper.sv
// PRG window mapper: page = base | (bank & ~mask), lockable config page at $5000-$5007.
// CG_CFG_READBACK_EN adds config register readback on the CPU data bus.
module cg_prg_window_mapper
  import cg_mapper_pkg::*;
#(
  parameter int N_WINDOWS   = 4,
  parameter int ADDR_OUT_W  = 27,
  parameter int BANK_W      = 8,
  parameter int INIT_CYCLES = 15
) (
  input logic                   m2,
  input logic                   rst_n,
  cg_prg_window_mapper_if.slave bus
);

  localparam int LOG_W       = cg_clog2(N_WINDOWS);
  localparam int WINDOW_BITS = 15 - LOG_W;
  localparam int BASE_W      = ADDR_OUT_W - WINDOW_BITS;
  localparam int SEL_W       = (LOG_W == 0) ? 1 : LOG_W;

  logic [BASE_W-1:0] base_q, base_d;
  logic [BASE_W-1:0] mask_q, mask_d;
  cfg_flags_t        flags_q, flags_d;
  logic [BANK_W-1:0] bank_q [N_WINDOWS];
  logic [BANK_W-1:0] bank_d [N_WINDOWS];

  logic              init_done;
  logic [SEL_W-1:0]  win_sel;
  logic [2:0]        reg_idx;
  logic              cfg_hit;
  logic              cfg_wr;
  logic              map_wr;
  logic [BANK_W-1:0] bank_eff;

  cg_init_timer #(.INIT_CYCLES(INIT_CYCLES)) u_init_timer (
    .m2       (m2),
    .rst_n    (rst_n),
    .init_done(init_done)
  );

  generate
    if (LOG_W == 0) begin : g_one_window
      assign win_sel = '0;
    end else begin : g_multi_window
      assign win_sel = bus.cpu_addr[14 -: LOG_W];
    end
  endgenerate

  assign reg_idx = bus.cpu_addr[2:0];
  assign cfg_hit = bus.romsel && (bus.cpu_addr[14:12] == CFG_PAGE) && (bus.cpu_addr[11:3] == 9'd0);
  // init_done is the pre-edge value, so the edge that completes the holdoff still rejects writes
  assign cfg_wr  = bus.wr_stb && !bus.cpu_rw && cfg_hit && !flags_q.lock && init_done;
  assign map_wr  = bus.wr_stb && !bus.cpu_rw && !bus.romsel && init_done;

  always_comb begin
    base_d  = base_q;
    mask_d  = mask_q;
    flags_d = flags_q;
    if (cfg_wr) begin
      case (reg_idx)
        REG_BASE_LO: for (int i = 0; i < BASE_W; i++) if (i < 8) base_d[i] = bus.cpu_wdata[i % 8];
        REG_BASE_HI: for (int i = 0; i < BASE_W; i++) if (i >= 8 && i < 16) base_d[i] = bus.cpu_wdata[i % 8];
        REG_MASK_LO: for (int i = 0; i < BASE_W; i++) if (i < 8) mask_d[i] = bus.cpu_wdata[i % 8];
        REG_MASK_HI: for (int i = 0; i < BASE_W; i++) if (i >= 8 && i < 16) mask_d[i] = bus.cpu_wdata[i % 8];
        REG_FLAGS: begin
          flags_d.sram_enable  = bus.cpu_wdata[FLAG_SRAM_EN];
          flags_d.prg_write_en = bus.cpu_wdata[FLAG_PRG_WE];
          flags_d.fixed_last   = bus.cpu_wdata[FLAG_FIXED];
          flags_d.lock         = bus.cpu_wdata[FLAG_LOCK];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int w = 0; w < N_WINDOWS; w++) bank_d[w] = bank_q[w];
    if (map_wr) begin
      for (int b = 0; b < BANK_W; b++) begin
        bank_d[win_sel][b] = (b < 8) ? bus.cpu_wdata[b % 8] : 1'b0;
      end
    end
  end

  always_ff @(posedge m2) begin
    if (!rst_n) begin
      base_q  <= '0;
      mask_q  <= '1;
      flags_q <= '0;
      for (int w = 0; w < N_WINDOWS; w++) bank_q[w] <= '0;
    end else begin
      base_q  <= base_d;
      mask_q  <= mask_d;
      flags_q <= flags_d;
      for (int w = 0; w < N_WINDOWS; w++) bank_q[w] <= bank_d[w];
    end
  end

  always_comb begin
    bank_eff = bank_q[win_sel];
    if (flags_q.fixed_last && (win_sel == SEL_W'(N_WINDOWS - 1))) bank_eff = '1;
  end

  assign bus.flash_page   = base_q | (BASE_W'(bank_eff) & ~mask_q);
  assign bus.sram_enable  = flags_q.sram_enable;
  assign bus.prg_write_en = flags_q.prg_write_en;
  assign bus.init_done    = init_done;
  assign bus.cfg_locked   = flags_q.lock;

`ifdef CG_CFG_READBACK_EN
  logic [7:0] rdata_c;

  always_comb begin
    rdata_c = 8'h00;
    case (reg_idx)
      REG_BASE_LO: for (int i = 0; i < BASE_W; i++) if (i < 8) rdata_c[i % 8] = base_q[i];
      REG_BASE_HI: for (int i = 0; i < BASE_W; i++) if (i >= 8 && i < 16) rdata_c[i % 8] = base_q[i];
      REG_MASK_LO: for (int i = 0; i < BASE_W; i++) if (i < 8) rdata_c[i % 8] = mask_q[i];
      REG_MASK_HI: for (int i = 0; i < BASE_W; i++) if (i >= 8 && i < 16) rdata_c[i % 8] = mask_q[i];
      REG_FLAGS:   rdata_c = {flags_q.lock, 4'b0000, flags_q.fixed_last,
                              flags_q.prg_write_en, flags_q.sram_enable};
      default:     rdata_c = 8'h00;
    endcase
  end

  assign bus.cpu_rdata    = rdata_c;
  assign bus.cpu_rdata_oe = bus.cpu_rw && bus.romsel && (bus.cpu_addr[14:3] == 12'hA00);
`else
  assign bus.cpu_rdata    = 8'h00;
  assign bus.cpu_rdata_oe = 1'b0;
`endif

endmodule

// File: tb/tb_cg_prg_window_mapper.sv
// Bench for cg_prg_window_mapper: init holdoff, translation tables, lock, reset race, readback.
module tb_cg_prg_window_mapper;

  localparam int INIT_CYCLES = 15;

  typedef struct {
    logic        romsel;
    logic [14:0] addr;
    logic [13:0] exp_page;
  } vec_t;

  logic m2;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [13:0] sb_q[$];
  vec_t vecs[8];

  cg_prg_window_mapper_if #(.BASE_W(14)) bus ();

  cg_prg_window_mapper #(
    .N_WINDOWS  (4),
    .ADDR_OUT_W (27),
    .BANK_W     (8),
    .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .m2   (m2),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic wr(input logic rs, input logic [14:0] a, input logic [7:0] d);
    @(negedge m2);
    bus.romsel    = rs;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.wr_stb    = 1'b1;
    @(posedge m2);
    #1;
    bus.wr_stb = 1'b0;
    bus.cpu_rw = 1'b1;
  endtask

  task automatic page(input string nm, input logic rs, input logic [14:0] a, input logic [13:0] exp);
    logic [13:0] e;
    @(negedge m2);
    bus.romsel   = rs;
    bus.cpu_rw   = 1'b1;
    bus.cpu_addr = a;
    sb_q.push_back(exp);
    #1;
    e = sb_q.pop_front();
    chk(nm, 16'(bus.flash_page), 16'(e));
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < 8; i++) begin
      page($sformatf("%s[%0d]", nm, i), vecs[i].romsel, vecs[i].addr, vecs[i].exp_page);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.romsel    = 1'b1;
    bus.cpu_rw    = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.wr_stb    = 1'b0;
    repeat (3) tick();

    chk("rst_init_done", 16'(bus.init_done), 16'h0);
    chk("rst_locked", 16'(bus.cfg_locked), 16'h0);
    chk("rst_sram_en", 16'(bus.sram_enable), 16'h0);
    chk("rst_prg_we", 16'(bus.prg_write_en), 16'h0);
    page("rst_page", 1'b0, 15'h0000, 14'h0000);

    // Holdoff: edge 5 write is dropped, init_done rises only after edge 15
    @(negedge m2);
    rst_n = 1'b1;
    repeat (4) tick();
    wr(1'b1, 15'h5000, 8'h12);
    repeat (9) tick();
    chk("init_done_edge14", 16'(bus.init_done), 16'h0);
    tick();
    chk("init_done_edge15", 16'(bus.init_done), 16'h1);
    page("early_base_ignored", 1'b0, 15'h0000, 14'h0000);
    wr(1'b1, 15'h5000, 8'h12);
    page("base_lo_write", 1'b0, 15'h0000, 14'h0012);

    // Open mask, zero base, then mapper writes
    wr(1'b1, 15'h5000, 8'h00);
    wr(1'b1, 15'h5002, 8'h00);
    wr(1'b1, 15'h5003, 8'h00);
    wr(1'b0, 15'h4000, 8'h07);
    page("bank2_c123", 1'b0, 15'h4123, 14'h0007);
    page("bank0_still0", 1'b0, 15'h0000, 14'h0000);
    wr(1'b0, 15'h0000, 8'h11);
    wr(1'b0, 15'h2000, 8'h22);
    wr(1'b0, 15'h6000, 8'h44);

    vecs[0] = '{1'b0, 15'h0000, 14'h0011};
    vecs[1] = '{1'b0, 15'h1FFF, 14'h0011};
    vecs[2] = '{1'b0, 15'h2000, 14'h0022};
    vecs[3] = '{1'b0, 15'h4123, 14'h0007};
    vecs[4] = '{1'b0, 15'h5FFF, 14'h0007};
    vecs[5] = '{1'b0, 15'h6000, 14'h0044};
    vecs[6] = '{1'b0, 15'h7FFF, 14'h0044};
    vecs[7] = '{1'b1, 15'h4000, 14'h0007};
    run_table("open_mask");

    // base=0x0100, mask=0x3FF0 (upper bits of 0xFF discarded)
    wr(1'b1, 15'h5001, 8'h01);
    wr(1'b1, 15'h5002, 8'hF0);
    wr(1'b1, 15'h5003, 8'hFF);
    wr(1'b0, 15'h2000, 8'h35);
    wr(1'b1, 15'h5008, 8'h55);
    vecs[0] = '{1'b0, 15'h2000, 14'h0105};
    vecs[1] = '{1'b0, 15'h0000, 14'h0101};
    vecs[2] = '{1'b0, 15'h4000, 14'h0107};
    vecs[3] = '{1'b0, 15'h6000, 14'h0104};
    vecs[4] = '{1'b0, 15'h3FFF, 14'h0105};
    vecs[5] = '{1'b1, 15'h0123, 14'h0101};
    vecs[6] = '{1'b0, 15'h7ABC, 14'h0104};
    vecs[7] = '{1'b0, 15'h5000, 14'h0107};
    run_table("masked");

    wr(1'b1, 15'h5004, 8'h03);
    chk("flags03_sram", 16'(bus.sram_enable), 16'h1);
    chk("flags03_prgwe", 16'(bus.prg_write_en), 16'h1);
    chk("flags03_unlocked", 16'(bus.cfg_locked), 16'h0);

    // Fixed-last plus lock
    wr(1'b1, 15'h5004, 8'h84);
    chk("locked", 16'(bus.cfg_locked), 16'h1);
    chk("flags84_sram", 16'(bus.sram_enable), 16'h0);
    page("fixed_last_e000", 1'b0, 15'h6000, 14'h010F);
    page("fixed_not_c000", 1'b0, 15'h4000, 14'h0107);
    wr(1'b1, 15'h5000, 8'h55);
    page("locked_base_ignored", 1'b0, 15'h0000, 14'h0101);
    wr(1'b1, 15'h5004, 8'h00);
    chk("still_locked", 16'(bus.cfg_locked), 16'h1);
    wr(1'b0, 15'h4000, 8'h0A);
    page("locked_mapper_write", 1'b0, 15'h4000, 14'h010A);

    // Reset wins over a simultaneous config write
    @(negedge m2);
    rst_n         = 1'b0;
    bus.romsel    = 1'b1;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 15'h5002;
    bus.cpu_wdata = 8'h00;
    bus.wr_stb    = 1'b1;
    tick();
    bus.wr_stb = 1'b0;
    bus.cpu_rw = 1'b1;
    tick();
    chk("rst2_locked", 16'(bus.cfg_locked), 16'h0);
    chk("rst2_init_done", 16'(bus.init_done), 16'h0);
    page("rst2_page", 1'b0, 15'h6000, 14'h0000);
    @(negedge m2);
    rst_n = 1'b1;
    repeat (INIT_CYCLES) tick();
    chk("rst2_init_again", 16'(bus.init_done), 16'h1);
    wr(1'b0, 15'h4000, 8'hFF);
    page("rst2_mask_all_ones", 1'b0, 15'h4000, 14'h0000);

    wr(1'b1, 15'h5000, 8'h12);
    wr(1'b1, 15'h5001, 8'hFF);
    wr(1'b1, 15'h5004, 8'h83);
    chk("flags83_locked", 16'(bus.cfg_locked), 16'h1);
    page("base_3f12", 1'b0, 15'h0000, 14'h3F12);

    @(negedge m2);
    bus.romsel   = 1'b1;
    bus.cpu_rw   = 1'b1;
    bus.cpu_addr = 15'h5004;
    #1;
`ifdef CG_CFG_READBACK_EN
    chk("rb_flags_oe", 16'(bus.cpu_rdata_oe), 16'h1);
    chk("rb_flags", 16'(bus.cpu_rdata), 16'h0083);
    bus.cpu_addr = 15'h5000;
    #1;
    chk("rb_base_lo", 16'(bus.cpu_rdata), 16'h0012);
    bus.cpu_addr = 15'h5001;
    #1;
    chk("rb_base_hi", 16'(bus.cpu_rdata), 16'h003F);
    bus.cpu_addr = 15'h5005;
    #1;
    chk("rb_idx5", 16'(bus.cpu_rdata), 16'h0000);
    bus.cpu_addr = 15'h5008;
    #1;
    chk("rb_5008_oe", 16'(bus.cpu_rdata_oe), 16'h0);
    bus.cpu_addr = 15'h5004;
    bus.cpu_rw   = 1'b0;
    #1;
    chk("rb_write_oe", 16'(bus.cpu_rdata_oe), 16'h0);
    bus.cpu_rw = 1'b1;
`else
    chk("no_rb_oe", 16'(bus.cpu_rdata_oe), 16'h0);
    chk("no_rb_data", 16'(bus.cpu_rdata), 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
